// File: rtl/otp_stream_ctrl.sv
// ============================================================================
// otp_stream_ctrl - one-time-pad stream sequencer: accepts a message/key pair
// and emits msg^key one nibble per downstream handshake, MSB nibble first.
// Optional key-reuse rejection is built when OTP_KEY_REUSE_GUARD_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module otp_stream_ctrl #(
  parameter int MSG_SIZE = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MSG_SIZE-1:0] msg_in,
  input  logic [MSG_SIZE-1:0] key_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [3:0]          nib_out,
  output logic                nib_valid,
  input  logic                nib_ready,
  output logic                nib_last,
  output logic                busy,
  output logic                done,
  output logic                key_err
);

  localparam int NIBS  = MSG_SIZE / 4;
  localparam int CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [MSG_SIZE-1:0] msg_sr;
  logic [MSG_SIZE-1:0] key_sr;
  logic [CNT_W-1:0]    cnt;
  logic                last_nib;
  logic                reuse;

  assign last_nib = (cnt == CNT_W'(NIBS - 1));

`ifdef OTP_KEY_REUSE_GUARD_EN
  logic [MSG_SIZE-1:0] last_key;
  logic                key_seen;
  logic                key_err_q;

  assign reuse = key_seen && (key_in == last_key);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_key  <= '0;
      key_seen  <= 1'b0;
      key_err_q <= 1'b0;
    end else begin
      key_err_q <= 1'b0;
      if (state == IDLE && in_valid) begin
        if (reuse) begin
          key_err_q <= 1'b1;
        end else begin
          last_key <= key_in;
          key_seen <= 1'b1;
        end
      end
    end
  end

  assign key_err = !rst && key_err_q;
`else
  assign reuse   = 1'b0;
  assign key_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      msg_sr <= '0;
      key_sr <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A rejected (reused-key) handshake is consumed but leaves us in IDLE.
          if (in_valid && !reuse) begin
            msg_sr <= msg_in;
            key_sr <= key_in;
            cnt    <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (nib_ready) begin
            if (last_nib) begin
              state <= DONE;
            end else begin
              msg_sr <= {msg_sr[MSG_SIZE-5:0], 4'h0};
              key_sr <= {key_sr[MSG_SIZE-5:0], 4'h0};
              cnt    <= cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode held state only; rst forces them all low while asserted.
  always_comb begin
    in_ready  = !rst && (state == IDLE);
    nib_valid = !rst && (state == SEND);
    nib_last  = nib_valid && last_nib;
    busy      = !rst && ((state == SEND) || (state == DONE));
    done      = !rst && (state == DONE);
    nib_out   = 4'h0;
    if (nib_valid) begin
      nib_out = msg_sr[MSG_SIZE-1 -: 4] ^ key_sr[MSG_SIZE-1 -: 4];
    end
  end

endmodule

`default_nettype wire
